// File: rtl/io_pkg.sv
// Shared opcodes, 7-segment patterns, sequencer state encoding and address
// constants for the board I/O sequencer.
package io_pkg;

  localparam logic [5:0] OP_OUT = 6'b011100;
  localparam logic [5:0] OP_IN  = 6'b011011;

  // Active-low patterns, bit0 = segment g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [4:0] ADDR_SW_MAX = 5'd17;
  localparam logic [4:0] ADDR_KEY1   = 5'd19;
  localparam logic [4:0] ADDR_KEY2   = 5'd20;
  localparam logic [4:0] ADDR_KEY3   = 5'd21;

  typedef enum logic [2:0] {IDLE, CONV, READ, WRITE, FIN} state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/io_bcd_serial.sv
// Serial double-dabble: binary magnitude to three BCD digits, one bit per cycle,
// MSB first, with add-3 correction applied before every shift.
module io_bcd_serial #(
  parameter int unsigned CONV_BITS = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [CONV_BITS-1:0] i_mag,
  output logic                 o_last,
  output logic [3:0]           o_hundreds,
  output logic [3:0]           o_tens,
  output logic [3:0]           o_units
);

  localparam int unsigned CW = $clog2(CONV_BITS + 1);

  logic [CONV_BITS-1:0] r_bin;
  logic [11:0]          r_bcd;
  logic [CW-1:0]        r_cnt;
  logic [11:0]          w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_mag;
      r_bcd <= '0;
      r_cnt <= CW'(CONV_BITS);
    end else if (r_cnt != '0) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign o_last     = (r_cnt == CW'(1));
  assign o_hundreds = r_bcd[11:8];
  assign o_tens     = r_bcd[7:4];
  assign o_units    = r_bcd[3:0];

endmodule

// File: rtl/io_sequencer.sv
// Board I/O controller: one CPU IN/OUT request at a time; OUT converts to BCD and
// updates 7-seg displays, IN samples synchronized switches/keys.
module io_sequencer
  import io_pkg::*;
#(
  parameter int unsigned CONV_BITS   = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  opcode,
  input  logic [4:0]  address,
  input  logic [31:0] data,
  input  logic [17:0] sw,
  input  logic [2:0]  key,
  output logic        busy,
  output logic        done,
  output logic [31:0] in_data,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7
);

  state_t        r_state;
  logic          r_busy, r_done, r_neg;
  logic [4:0]    r_addr;
  logic [31:0]   r_in_data;
  logic [6:0]    r_hex [8];
  logic [17:0]   r_sw_pipe  [SYNC_STAGES];
  logic [2:0]    r_key_pipe [SYNC_STAGES];

  logic                 w_accept, w_start, w_last, w_unused_data;
  logic [CONV_BITS-1:0] w_mag;
  logic [3:0]           w_hun, w_ten, w_unit;
  logic [17:0]          w_sw_s;
  logic [2:0]           w_key_s;
  logic [31:0]          w_in_word;

  // The done cycle is still IDLE but busy, so req there is ignored.
  assign w_accept      = (r_state == IDLE) && req && !r_busy;
  assign w_start       = w_accept && (opcode == OP_OUT);
  // A CONV_BITS-bit two's complement negation yields 2^(N-1) for the most negative value.
  assign w_mag         = data[CONV_BITS-1] ? (~data[CONV_BITS-1:0] + CONV_BITS'(1))
                                           : data[CONV_BITS-1:0];
  assign w_unused_data = ^data[31:CONV_BITS];

  io_bcd_serial #(.CONV_BITS(CONV_BITS)) u_bcd (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_start   (w_start),
    .i_mag     (w_mag),
    .o_last    (w_last),
    .o_hundreds(w_hun),
    .o_tens    (w_ten),
    .o_units   (w_unit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sw_pipe[i]  <= '0;
        r_key_pipe[i] <= '0;
      end
    end else begin
      r_sw_pipe[0]  <= sw;
      r_key_pipe[0] <= key;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sw_pipe[i]  <= r_sw_pipe[i-1];
        r_key_pipe[i] <= r_key_pipe[i-1];
      end
    end
  end

  assign w_sw_s  = r_sw_pipe[SYNC_STAGES-1];
  assign w_key_s = r_key_pipe[SYNC_STAGES-1];

  always_comb begin
    w_in_word = '0;
    if (r_addr <= ADDR_SW_MAX) w_in_word = {{14{w_sw_s[17]}}, w_sw_s};
    else if (r_addr == ADDR_KEY1) w_in_word = {31'b0, w_key_s[0]};
    else if (r_addr == ADDR_KEY2) w_in_word = {31'b0, w_key_s[1]};
    else if (r_addr == ADDR_KEY3) w_in_word = {31'b0, w_key_s[2]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
      r_addr    <= '0;
      r_in_data <= '0;
      for (int unsigned i = 0; i < 8; i++) r_hex[i] <= SEG_0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_busy <= w_accept;
          if (w_accept) begin
            r_addr <= address;
            r_neg  <= data[CONV_BITS-1];
            if (opcode == OP_OUT)     r_state <= CONV;
            else if (opcode == OP_IN) r_state <= READ;
            else                      r_state <= FIN;
          end
        end
        CONV: if (w_last) r_state <= WRITE;
        WRITE: begin
          case (r_addr)
            5'd0: begin
              r_hex[0] <= seg_encode(w_unit);
              r_hex[1] <= seg_encode(w_ten);
              r_hex[2] <= seg_encode(w_hun);
              r_hex[3] <= r_neg ? SEG_MINUS : SEG_BLANK;
            end
            5'd1, 5'd2, 5'd3, 5'd5, 5'd7: r_hex[r_addr[2:0]] <= seg_encode(w_unit);
            5'd4: begin
              r_hex[4] <= seg_encode(w_unit);
              r_hex[5] <= seg_encode(w_ten);
            end
            5'd6: begin
              r_hex[6] <= seg_encode(w_unit);
              r_hex[7] <= seg_encode(w_ten);
            end
            default: ;
          endcase
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        READ: begin
          r_in_data <= w_in_word;
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        FIN: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign in_data = r_in_data;
  assign hex0    = r_hex[0];
  assign hex1    = r_hex[1];
  assign hex2    = r_hex[2];
  assign hex3    = r_hex[3];
  assign hex4    = r_hex[4];
  assign hex5    = r_hex[5];
  assign hex6    = r_hex[6];
  assign hex7    = r_hex[7];

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed and random IN/OUT/NOP requests checked against
// an arithmetic model of display digits, address map and read words.
module tb_io_sequencer;

  localparam logic [5:0] T_OUT = 6'b011100;
  localparam logic [5:0] T_IN  = 6'b011011;
  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] SMIN  = 7'b1111110;
  localparam logic [6:0] SBLK  = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset, req;
  logic [5:0]  opcode;
  logic [4:0]  address;
  logic [31:0] data;
  logic [17:0] sw;
  logic [2:0]  key;
  logic        busy, done;
  logic [31:0] in_data;
  logic [6:0]  hx0, hx1, hx2, hx3, hx4, hx5, hx6, hx7;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
  logic [6:0]  exp_hex [8];
  logic [31:0] exp_in;

  always #5 clock = ~clock;

  io_sequencer #(.CONV_BITS(10), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .req(req), .opcode(opcode), .address(address),
    .data(data), .sw(sw), .key(key), .busy(busy), .done(done), .in_data(in_data),
    .hex0(hx0), .hex1(hx1), .hex2(hx2), .hex3(hx3),
    .hex4(hx4), .hex5(hx5), .hex6(hx6), .hex7(hx7)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] get_hex(input int i);
    case (i)
      0: return hx0;
      1: return hx1;
      2: return hx2;
      3: return hx3;
      4: return hx4;
      5: return hx5;
      6: return hx6;
      default: return hx7;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_hex%0d", tag, i), {25'b0, get_hex(i)}, {25'b0, exp_hex[i]});
    check($sformatf("%s_in_data", tag), in_data, exp_in);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_hex[i] = S0;
    exp_in = '0;
  endtask

  task automatic model_out(input logic [4:0] a, input logic [31:0] d);
    int v, mag, h, t, u;
    v = int'({22'b0, d[9:0]});
    if (d[9]) v = v - 1024;
    mag = (v < 0) ? -v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    case (a)
      5'd0: begin
        exp_hex[0] = seg_tab[u];
        exp_hex[1] = seg_tab[t];
        exp_hex[2] = seg_tab[h];
        exp_hex[3] = (v < 0) ? SMIN : SBLK;
      end
      5'd1, 5'd2, 5'd3, 5'd5, 5'd7: exp_hex[a] = seg_tab[u];
      5'd4: begin exp_hex[4] = seg_tab[u]; exp_hex[5] = seg_tab[t]; end
      5'd6: begin exp_hex[6] = seg_tab[u]; exp_hex[7] = seg_tab[t]; end
      default: ;
    endcase
  endtask

  task automatic model_in(input logic [4:0] a);
    if (a <= 5'd17)      exp_in = {{14{sw[17]}}, sw};
    else if (a == 5'd19) exp_in = {31'b0, key[0]};
    else if (a == 5'd20) exp_in = {31'b0, key[1]};
    else if (a == 5'd21) exp_in = {31'b0, key[2]};
    else                 exp_in = '0;
  endtask

  // One request from idle; noisy mode scrambles inputs and toggles req while busy.
  task automatic run_op(input logic [5:0] op, input logic [4:0] a, input logic [31:0] d,
                        input bit noisy);
    int lat;
    bit got;
    opcode = op; address = a; data = d; req = 1'b1;
    tick();
    req = 1'b0;
    if (noisy) begin
      opcode = 6'($urandom); address = 5'($urandom); data = $urandom;
    end
    check("busy_set", {31'b0, busy}, 32'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      if (noisy) req = 1'($urandom);
      tick();
      lat++;
      if (done) got = 1'b1;
    end
    check("done_seen", {31'b0, got}, 32'd1);
    check("latency", lat, (op == T_OUT) ? 32'd11 : 32'd1);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    if (op == T_OUT) model_out(a, d);
    else if (op == T_IN) model_in(a);
    check_all("result");
    req = noisy ? 1'($urandom) : 1'b0;
    tick();
    req = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_clear", {31'b0, busy}, 32'd0);
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    bit any_done;
    logic [5:0] rop;
    reset = 1'b1; req = 1'b0; opcode = '0; address = '0; data = '0; sw = '0; key = '0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check_all("rst");

    run_op(T_OUT, 5'd0, 32'd123, 1'b0);
    check("t1_hex0", {25'b0, hx0}, 32'b0000110);
    check("t1_hex1", {25'b0, hx1}, 32'b0010010);
    check("t1_hex2", {25'b0, hx2}, 32'b1001111);
    check("t1_hex3", {25'b0, hx3}, 32'b1111111);

    run_op(T_OUT, 5'd0, 32'h3FF, 1'b0);
    check("t2_hex0", {25'b0, hx0}, 32'b1001111);
    check("t2_hex2", {25'b0, hx2}, 32'b0000001);
    check("t2_hex3", {25'b0, hx3}, 32'b1111110);
    run_op(T_OUT, 5'd0, 32'h200, 1'b0);
    check("t2_512_hex2", {25'b0, hx2}, 32'b0100100);

    sw = 18'h20001; settle();
    run_op(T_IN, 5'd5, $urandom, 1'b0);
    check("t3_sw", in_data, 32'hFFFE0001);
    key = 3'b010; settle();
    run_op(T_IN, 5'd20, $urandom, 1'b0);
    check("t3_key2", in_data, 32'd1);

    run_op(T_OUT, 5'd6, 32'd47, 1'b0);
    check("t4_hex6", {25'b0, hx6}, 32'b0001111);
    check("t4_hex7", {25'b0, hx7}, 32'b1001100);
    run_op(T_OUT, 5'd9, $urandom, 1'b0);
    run_op(6'b000000, 5'd0, $urandom, 1'b0);
    run_op(T_OUT, 5'd0, 32'd555, 1'b1);

    // Reset in the middle of a conversion, with a simultaneous request.
    opcode = T_OUT; address = 5'd0; data = $urandom; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1; req = 1'b1;
    tick();
    reset = 1'b0; req = 1'b0;
    model_reset();
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check_all("mid_rst");
    any_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) any_done = 1'b1;
    end
    check("no_activity_after_rst", {31'b0, any_done}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      sw = 18'($urandom); key = 3'($urandom);
      settle();
      case ($urandom_range(0, 4))
        0, 1:    rop = T_OUT;
        2, 3:    rop = T_IN;
        default: rop = 6'($urandom);
      endcase
      run_op(rop, 5'($urandom), $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
